// File: rtl/cmplxmul_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cmplxmul_pipe_pkg
//   Shared definitions for the pipelined complex multiplier.
//   - CMPLXMUL_LAT : input-accept edge to output-valid edge distance, in cycles.
//   - conj_e       : per-beat multiply mode carried down the pipeline.
//   Complex values are packed {im, re}, with re in the low half.
// ---------------------------------------------------------------------------
package cmplxmul_pipe_pkg;

  localparam int CMPLXMUL_LAT = 3;

  typedef enum logic {
    CONJ_OFF = 1'b0,  // op1 * op2
    CONJ_ON  = 1'b1   // op1 * conj(op2)
  } conj_e;

endpackage

// File: rtl/cmplxmul_pipe_rndsat.sv
// ---------------------------------------------------------------------------
// cmplx_rndsat
//   Combinational round-half-up, arithmetic right shift and saturation of one
//   signed component.
//   Ports:
//     din  in  IW  full-precision signed value
//     dout out OW  rounded, shifted, saturated value
//     ovf  out 1   1 when dout was clamped to a bound
// ---------------------------------------------------------------------------
module cmplx_rndsat #(
  parameter int IW    = 7,
  parameter int OW    = 6,
  parameter int SHIFT = 0
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 ovf
);

  // Half an output LSB, added before the shift; zero when nothing is shifted out.
  localparam int                 RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IW:0] RND_V   = (SHIFT > 0) ? ({{IW{1'b0}}, 1'b1} << RND_POS) : '0;
  // Output range expressed at the widened working width.
  localparam logic signed [IW:0] MAX_V   = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] MIN_V   = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  logic signed [IW:0] biased;
  logic signed [IW:0] shifted;

  // One extra bit keeps the rounding addend from wrapping the most positive input.
  always_comb begin
    biased  = {din[IW-1], din} + RND_V;
    shifted = biased >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[OW-1:0];
      ovf  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OW-1:0];
      ovf  = 1'b1;
    end else begin
      dout = shifted[OW-1:0];
      ovf  = 1'b0;
    end
  end

endmodule

// File: rtl/cmplxmul_pipe.sv
// ---------------------------------------------------------------------------
// cmplxmul_pipe
//   Pipelined, flow-controlled signed complex multiplier (FFT twiddle stage).
//   prod = op1*op2 or op1*conj(op2), rounded/shifted/saturated to OBW bits.
//   Register banks: S1 operands, S2 partial products, S3 full-precision sums,
//   then the output register. All banks share one enable, so a stall freezes
//   the whole pipe and bubbles are carried, not squeezed.
//   Ports:
//     clk, rst        clock (rising), asynchronous active-high reset
//     in_valid/ready  input handshake; in_ready = out_ready | ~out_valid
//     op1, op2        {im, re}, DBW-bit two's complement components
//     conj            1: multiply by conj(op2), sampled with the beat
//     out_valid/ready output handshake
//     prod            {im, re}, OBW-bit two's complement components
//     out_ovf         1 when either component saturated on this beat
// ---------------------------------------------------------------------------
module cmplxmul_pipe
  import cmplxmul_pipe_pkg::*;
#(
  parameter int DBW   = 3,
  parameter int OBW   = 2*DBW,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*DBW-1:0] op1,
  input  logic [2*DBW-1:0] op2,
  input  logic             conj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OBW-1:0] prod,
  output logic             out_ovf
);

  localparam int PW = 2*DBW;      // product width
  localparam int SW = 2*DBW + 1;  // sum width; holds 2*(-2^(DBW-1))^2 exactly

  logic en;

  // S1: captured operands
  logic                  s1_vld_q;
  logic signed [DBW-1:0] s1_re1_q, s1_im1_q, s1_re2_q, s1_im2_q;
  conj_e                 s1_conj_q;
  // S2: partial products
  logic                  s2_vld_q;
  logic signed [PW-1:0]  s2_pa_q, s2_pb_q, s2_pc_q, s2_pd_q;
  logic signed [PW-1:0]  s2_pa_d, s2_pb_d, s2_pc_d, s2_pd_d;
  conj_e                 s2_conj_q;
  // S3: full-precision sums
  logic                  s3_vld_q;
  logic signed [SW-1:0]  s3_re_q, s3_im_q;
  logic signed [SW-1:0]  s3_re_d, s3_im_d;
  // Output register
  logic                  out_vld_q;
  logic [2*OBW-1:0]      prod_q, prod_d;
  logic                  ovf_q, ovf_d;

  logic signed [OBW-1:0] rs_re, rs_im;
  logic                  ovf_re, ovf_im;

  // A full output register that is not being drained is the only stall source.
  assign en        = out_ready | ~out_vld_q;
  assign in_ready  = en;
  assign out_valid = out_vld_q;
  assign prod      = prod_q;
  assign out_ovf   = ovf_q;

  // Partial products, sign-extended to product width before multiplying.
  always_comb begin
    s2_pa_d = PW'(s1_re1_q) * PW'(s1_re2_q);
    s2_pb_d = PW'(s1_im1_q) * PW'(s1_im2_q);
    s2_pc_d = PW'(s1_re1_q) * PW'(s1_im2_q);
    s2_pd_d = PW'(s1_im1_q) * PW'(s1_re2_q);
  end

  // Combine products; conjugating op2 flips the sign of its imaginary part.
  always_comb begin
    s3_re_d = '0;
    s3_im_d = '0;
    if (s2_conj_q == CONJ_ON) begin
      s3_re_d = SW'(s2_pa_q) + SW'(s2_pb_q);
      s3_im_d = SW'(s2_pd_q) - SW'(s2_pc_q);
    end else begin
      s3_re_d = SW'(s2_pa_q) - SW'(s2_pb_q);
      s3_im_d = SW'(s2_pc_q) + SW'(s2_pd_q);
    end
  end

  cmplx_rndsat #(.IW(SW), .OW(OBW), .SHIFT(SHIFT)) u_rndsat_re (
    .din  (s3_re_q),
    .dout (rs_re),
    .ovf  (ovf_re)
  );

  cmplx_rndsat #(.IW(SW), .OW(OBW), .SHIFT(SHIFT)) u_rndsat_im (
    .din  (s3_im_q),
    .dout (rs_im),
    .ovf  (ovf_im)
  );

  // Narrowed result packed {im, re}.
  always_comb begin
    prod_d = {rs_im, rs_re};
    ovf_d  = ovf_re | ovf_im;
  end

  // Valid chain; a bubble at the input travels down as valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (en) begin
      s1_vld_q  <= in_valid;
      s2_vld_q  <= s1_vld_q;
      s3_vld_q  <= s2_vld_q;
      out_vld_q <= s3_vld_q;
    end
  end

  // S1 operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_re1_q  <= '0;
      s1_im1_q  <= '0;
      s1_re2_q  <= '0;
      s1_im2_q  <= '0;
      s1_conj_q <= CONJ_OFF;
    end else if (en) begin
      s1_re1_q  <= op1[DBW-1:0];
      s1_im1_q  <= op1[2*DBW-1:DBW];
      s1_re2_q  <= op2[DBW-1:0];
      s1_im2_q  <= op2[2*DBW-1:DBW];
      s1_conj_q <= conj_e'(conj);
    end
  end

  // S2 product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_pa_q   <= '0;
      s2_pb_q   <= '0;
      s2_pc_q   <= '0;
      s2_pd_q   <= '0;
      s2_conj_q <= CONJ_OFF;
    end else if (en) begin
      s2_pa_q   <= s2_pa_d;
      s2_pb_q   <= s2_pb_d;
      s2_pc_q   <= s2_pc_d;
      s2_pd_q   <= s2_pd_d;
      s2_conj_q <= s1_conj_q;
    end
  end

  // S3 sum registers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_re_q <= '0;
      s3_im_q <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      s3_re_q <= s3_re_d;
      s3_im_q <= s3_im_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cmplxmul_pipe.sv
// ---------------------------------------------------------------------------
// tb_cmplxmul_pipe
//   Three instances share one stimulus stream: A (OBW=6, SHIFT=0),
//   B (OBW=7, SHIFT=0), C (OBW=4, SHIFT=2). Since they share handshake
//   inputs they run in lock-step; results are compared as triples against an
//   integer reference model or against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_cmplxmul_pipe;
  import cmplxmul_pipe_pkg::*;

  localparam int DBW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        conj = 1'b0;
  logic        out_ready = 1'b1;
  logic [5:0]  op1 = '0;
  logic [5:0]  op2 = '0;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        out_ovf_a, out_ovf_b, out_ovf_c;
  logic [11:0] prod_a;
  logic [13:0] prod_b;
  logic [7:0]  prod_c;

  cmplxmul_pipe #(.DBW(DBW), .OBW(6), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .op1(op1), .op2(op2), .conj(conj), .out_valid(out_valid_a),
    .out_ready(out_ready), .prod(prod_a), .out_ovf(out_ovf_a));

  cmplxmul_pipe #(.DBW(DBW), .OBW(7), .SHIFT(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .op1(op1), .op2(op2), .conj(conj), .out_valid(out_valid_b),
    .out_ready(out_ready), .prod(prod_b), .out_ovf(out_ovf_b));

  cmplxmul_pipe #(.DBW(DBW), .OBW(4), .SHIFT(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .op1(op1), .op2(op2), .conj(conj), .out_valid(out_valid_c),
    .out_ready(out_ready), .prod(prod_c), .out_ovf(out_ovf_c));

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [7:0] re;
    logic signed [7:0] im;
    logic              ovf;
  } res_t;
  typedef struct packed {
    res_t a;
    res_t b;
    res_t c;
  } res3_t;
  typedef struct {
    int r1; int i1; int r2; int i2; bit cj;
  } stim_t;

  res3_t exp_q[$];
  res3_t got_q[$];
  stim_t stim_q[$];
  int    total = 0;
  int    bad   = 0;

  // ---- reference model: plain integer arithmetic --------------------------
  function automatic int narrow(input int full, input int obw, input int sh, output bit o);
    int t, hi, lo;
    t  = full + ((sh > 0) ? (1 << (sh - 1)) : 0);
    t  = t >>> sh;
    hi = (1 << (obw - 1)) - 1;
    lo = -(1 << (obw - 1));
    o  = 1'b0;
    if (t > hi) begin t = hi; o = 1'b1; end
    else if (t < lo) begin t = lo; o = 1'b1; end
    return t;
  endfunction

  function automatic res_t model(input stim_t s, input int obw, input int sh);
    int   fr, fi;
    bit   o1, o2;
    res_t r;
    if (s.cj) begin
      fr = s.r1 * s.r2 + s.i1 * s.i2;
      fi = s.i1 * s.r2 - s.r1 * s.i2;
    end else begin
      fr = s.r1 * s.r2 - s.i1 * s.i2;
      fi = s.r1 * s.i2 + s.i1 * s.r2;
    end
    r.re  = 8'(narrow(fr, obw, sh, o1));
    r.im  = 8'(narrow(fi, obw, sh, o2));
    r.ovf = o1 | o2;
    return r;
  endfunction

  function automatic res3_t mk3(input int ar, input int ai, input bit ao,
                                input int br, input int bi, input bit bo,
                                input int cr, input int ci, input bit co);
    res3_t t;
    t.a = '{re: 8'(ar), im: 8'(ai), ovf: ao};
    t.b = '{re: 8'(br), im: 8'(bi), ovf: bo};
    t.c = '{re: 8'(cr), im: 8'(ci), ovf: co};
    return t;
  endfunction

  function automatic string fmt3(input res3_t t);
    return $sformatf("a=(%0d,%0d,%0b) b=(%0d,%0d,%0b) c=(%0d,%0d,%0b)",
                     t.a.re, t.a.im, t.a.ovf, t.b.re, t.b.im, t.b.ovf,
                     t.c.re, t.c.im, t.c.ovf);
  endfunction

  function automatic stim_t rnd_stim(input bit cj);
    stim_t s;
    s.r1 = int'($urandom_range(7, 0)) - 4;
    s.i1 = int'($urandom_range(7, 0)) - 4;
    s.r2 = int'($urandom_range(7, 0)) - 4;
    s.i2 = int'($urandom_range(7, 0)) - 4;
    s.cj = cj;
    return s;
  endfunction

  // ---- monitor: record accepted beats (via model) and emitted beats -------
  always @(negedge clk) begin
    stim_t s;
    res3_t e;
    res3_t g;
    if (!rst) begin
      if (in_valid && in_ready_a) begin
        s.r1 = int'($signed(op1[2:0]));
        s.i1 = int'($signed(op1[5:3]));
        s.r2 = int'($signed(op2[2:0]));
        s.i2 = int'($signed(op2[5:3]));
        s.cj = conj;
        e.a = model(s, 6, 0);
        e.b = model(s, 7, 0);
        e.c = model(s, 4, 2);
        exp_q.push_back(e);
      end
      if (out_valid_a && out_ready) begin
        g.a = '{re: 8'($signed(prod_a[5:0])),  im: 8'($signed(prod_a[11:6])),  ovf: out_ovf_a};
        g.b = '{re: 8'($signed(prod_b[6:0])),  im: 8'($signed(prod_b[13:7])),  ovf: out_ovf_b};
        g.c = '{re: 8'($signed(prod_c[3:0])),  im: 8'($signed(prod_c[7:4])),   ovf: out_ovf_c};
        got_q.push_back(g);
      end
    end
  end

  // ---- stimulus helpers ---------------------------------------------------
  task automatic drive_beat(input stim_t s);
    op1  = {DBW'(s.i1), DBW'(s.r1)};
    op2  = {DBW'(s.i2), DBW'(s.r2)};
    conj = s.cj;
  endtask

  // Entered at posedge+1; returns cycles taken until every beat has left.
  task automatic run_stream(input int stall_at, input int stall_len, input bit rnd,
                            output int cyc, output bit to);
    bit acc;
    cyc = 0;
    while ((stim_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < 3000) begin
      if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
      else if (rnd) out_ready = ($urandom_range(3, 0) != 0);
      else out_ready = 1'b1;
      if (stim_q.size() > 0 && !(rnd && $urandom_range(4, 0) == 0)) begin
        drive_beat(stim_q[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) void'(stim_q.pop_front());
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    to = (cyc >= 3000);
  endtask

  // ---- tests --------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000) begin
      bad++; $display("FAIL reset_out_valid: got %b want 000", {out_valid_a, out_valid_b, out_valid_c});
    end
    total++;
    if (prod_a !== 12'd0 || prod_b !== 14'd0 || prod_c !== 8'd0) begin
      bad++; $display("FAIL reset_prod: got %h %h %h want 0", prod_a, prod_b, prod_c);
    end
    total++;
    if ({out_ovf_a, out_ovf_b, out_ovf_c} !== 3'b000) begin
      bad++; $display("FAIL reset_ovf: got %b want 000", {out_ovf_a, out_ovf_b, out_ovf_c});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111) begin
      bad++; $display("FAIL reset_in_ready: got %b want 111", {in_ready_a, in_ready_b, in_ready_c});
    end
  endtask

  task automatic test_directed();
    stim_t s;
    res3_t want[5];
    int    cyc;
    bit    to;
    s = '{r1: 1,  i1: 2,  r2: 3,  i2: -1, cj: 1'b0}; stim_q.push_back(s);
    s = '{r1: 1,  i1: 2,  r2: 3,  i2: -1, cj: 1'b1}; stim_q.push_back(s);
    s = '{r1: -4, i1: -4, r2: -4, i2: -4, cj: 1'b0}; stim_q.push_back(s);
    s = '{r1: 3,  i1: 0,  r2: 2,  i2: -2, cj: 1'b0}; stim_q.push_back(s);
    s = '{r1: -3, i1: 2,  r2: 3,  i2: -1, cj: 1'b0}; stim_q.push_back(s);
    want[0] = mk3(5, 5, 0,   5, 5, 0,    1, 1, 0);
    want[1] = mk3(1, 7, 0,   1, 7, 0,    0, 2, 0);
    want[2] = mk3(0, 31, 1,  0, 32, 0,   0, 7, 1);
    want[3] = mk3(6, -6, 0,  6, -6, 0,   2, -1, 0);
    want[4] = mk3(-7, 9, 0,  -7, 9, 0,   -2, 2, 0);
    run_stream(0, 0, 1'b0, cyc, to);
    total++;
    if (to || got_q.size() != 5) begin
      bad++; $display("FAIL directed_count: got %0d beats (timeout=%0b) want 5", got_q.size(), to);
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i]) begin
        bad++; $display("FAIL directed[%0d]: got %s want %s", i, fmt3(got_q[i]), fmt3(want[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    for (int i = 0; i < 12; i++) stim_q.push_back(rnd_stim(i[0]));
    run_stream(0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 12 + CMPLXMUL_LAT + 1) begin
      bad++; $display("FAIL b2b_cycles: got %0d (timeout=%0b) want %0d", cyc, to, 12 + CMPLXMUL_LAT + 1);
    end
    total++;
    if (got_q.size() != 12 || exp_q.size() != 12) begin
      bad++; $display("FAIL b2b_count: got %0d emitted %0d accepted want 12", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b[%0d]: got %s want %s", i, fmt3(got_q[i]), fmt3(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_stall();
    int          cyc;
    bit          acc;
    logic [36:0] snap;
    for (int i = 0; i < 8; i++) stim_q.push_back(rnd_stim(1'($urandom_range(1, 0))));
    cyc  = 0;
    snap = '0;
    while ((stim_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < 3000) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      if (stim_q.size() > 0) begin
        drive_beat(stim_q[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 5 && cyc < 9) begin
        total++;
        if ({in_ready_a, in_ready_b, in_ready_c, out_valid_a} !== 4'b0001) begin
          bad++; $display("FAIL stall_ready: cycle %0d got in_ready=%b out_valid=%b want 000/1",
                          cyc, {in_ready_a, in_ready_b, in_ready_c}, out_valid_a);
        end
        if (cyc == 5) begin
          snap = {prod_a, prod_b, prod_c, out_ovf_a, out_ovf_b, out_ovf_c};
        end else begin
          total++;
          if ({prod_a, prod_b, prod_c, out_ovf_a, out_ovf_b, out_ovf_c} !== snap) begin
            bad++; $display("FAIL stall_hold: cycle %0d got %h want %h", cyc,
                            {prod_a, prod_b, prod_c, out_ovf_a, out_ovf_b, out_ovf_c}, snap);
          end
        end
      end
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) void'(stim_q.pop_front());
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (cyc >= 3000 || got_q.size() != 8 || exp_q.size() != 8) begin
      bad++; $display("FAIL stall_count: got %0d emitted %0d accepted want 8", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall[%0d]: got %s want %s", i, fmt3(got_q[i]), fmt3(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_rst_inflight();
    stim_t s;
    int    cyc;
    bit    to;
    @(posedge clk); #1;
    out_ready = 1'b1;
    s = '{r1: 1, i1: 2, r2: 3, i2: -1, cj: 1'b0};
    drive_beat(s);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (out_valid_a !== 1'b1 || prod_a === 12'd0) begin
      bad++; $display("FAIL rst_pre: got out_valid=%b prod=%h want 1 and nonzero", out_valid_a, prod_a);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000 ||
        prod_a !== 12'd0 || prod_b !== 14'd0 || prod_c !== 8'd0 ||
        {out_ovf_a, out_ovf_b, out_ovf_c} !== 3'b000) begin
      bad++; $display("FAIL rst_async: got valid=%b prod=%h/%h/%h want 000 and 0",
                      {out_valid_a, out_valid_b, out_valid_c}, prod_a, prod_b, prod_c);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    got_q.delete();
    total++;
    if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111 || out_valid_a !== 1'b0) begin
      bad++; $display("FAIL rst_release: got in_ready=%b out_valid=%b want 111/0",
                      {in_ready_a, in_ready_b, in_ready_c}, out_valid_a);
    end
    stim_q.push_back(rnd_stim(1'b1));
    run_stream(0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 1 + CMPLXMUL_LAT + 1 || got_q.size() != 1) begin
      bad++; $display("FAIL rst_latency: got %0d cycles %0d beats want %0d cycles 1 beat",
                      cyc, got_q.size(), 1 + CMPLXMUL_LAT + 1);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rst_beat[%0d]: got %s want %s", i, fmt3(got_q[i]), fmt3(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    int cyc;
    bit to;
    for (int i = 0; i < 80; i++) stim_q.push_back(rnd_stim(1'($urandom_range(1, 0))));
    run_stream(0, 0, 1'b1, cyc, to);
    total++;
    if (to || got_q.size() != 80 || exp_q.size() != 80) begin
      bad++; $display("FAIL random_count: got %0d emitted %0d accepted (timeout=%0b) want 80",
                      got_q.size(), exp_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL random[%0d]: got %s want %s", i, fmt3(got_q[i]), fmt3(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_rst_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
